// File: rtl/uart_result_server_pkg.sv
// Shared definitions for the UART result server: default opcodes, frame header,
// FSM state encoding, response kinds and the response-length helper.
package uart_result_server_pkg;

  localparam logic [7:0] DEF_CMD_DIGIT  = 8'hCC;
  localparam logic [7:0] DEF_CMD_SCORES = 8'hCD;
  localparam logic [7:0] DEF_CMD_STATUS = 8'hCE;
  localparam logic [7:0] DEF_CMD_ALL    = 8'hCF;
  localparam logic [7:0] DEF_FRAME_HDR  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RSP_DIGIT,
    RSP_SCORES,
    RSP_STATUS,
    RSP_ALL
  } rsp_e;

  // Number of bytes sent for a response kind, given the raw score byte count.
  function automatic int unsigned resp_len(rsp_e kind, int unsigned n_score_bytes);
    case (kind)
      RSP_SCORES: return n_score_bytes;
      RSP_ALL:    return n_score_bytes + 3;
      default:    return 1;
    endcase
  endfunction

endpackage

// File: rtl/result_snapshot_buf.sv
// Double-buffered result snapshot. The front copy is what gets transmitted;
// results arriving mid-response park in the back copy until the response ends.
module result_snapshot_buf
  import uart_result_server_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32,
  parameter int IDX_W       = 4,
  parameter int SEL_W       = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_wr_front,
  input  logic                           i_wr_back,
  input  logic                           i_swap,
  input  logic [IDX_W-1:0]               i_digit,
  input  logic [NUM_CLASSES*SCORE_W-1:0] i_scores,
  input  logic [SEL_W-1:0]               i_byte_idx,
  output logic [7:0]                     o_byte,
  output logic [IDX_W-1:0]               o_digit,
  output logic                           o_pending
);

  localparam int NB = NUM_CLASSES * SCORE_W / 8;

  logic [IDX_W-1:0]               r_front_digit;
  logic [NUM_CLASSES*SCORE_W-1:0] r_front_scores;
  logic [IDX_W-1:0]               r_back_digit;
  logic [NUM_CLASSES*SCORE_W-1:0] r_back_scores;
  logic                           r_pending;
  logic [SEL_W+2:0]               w_bit_off;

  // Capture into front or back, and promote back to front when a response ends.
  always_ff @(posedge clk) begin
    // NOTE: the snapshot registers are cleared on reset on purpose: a scores
    // request before any result must read back as all zeros.
    if (!rst) begin
      r_front_digit  <= '0;
      r_front_scores <= '0;
      r_back_digit   <= '0;
      r_back_scores  <= '0;
      r_pending      <= 1'b0;
    end else begin
      if (i_wr_front) begin
        r_front_digit  <= i_digit;
        r_front_scores <= i_scores;
      end else if (i_swap && r_pending) begin
        r_front_digit  <= r_back_digit;
        r_front_scores <= r_back_scores;
      end
      if (i_wr_back) begin
        r_back_digit  <= i_digit;
        r_back_scores <= i_scores;
        r_pending     <= 1'b1;
      end else if (i_swap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign w_bit_off = {i_byte_idx, 3'b000};

  // Select score byte i_byte_idx (class 0 first, little-endian per score).
  always_comb begin
    // NOTE: default first so every path assigns o_byte and no latch is inferred.
    o_byte = 8'h00;
    if (32'(i_byte_idx) < NB) o_byte = r_front_scores[w_bit_off +: 8];
  end

  assign o_digit   = r_front_digit;
  assign o_pending = r_pending;

endmodule

// File: rtl/uart_result_server.sv
// UART response engine: decodes host opcodes, walks the response byte by byte
// through uart_tx, keeps the frame checksum and the result counters.
module uart_result_server
  import uart_result_server_pkg::*;
#(
  parameter int         NUM_CLASSES = 10,
  parameter int         SCORE_W     = 32,
  parameter int         IDX_W       = 4,
  parameter logic [7:0] CMD_DIGIT   = DEF_CMD_DIGIT,
  parameter logic [7:0] CMD_SCORES  = DEF_CMD_SCORES,
  parameter logic [7:0] CMD_STATUS  = DEF_CMD_STATUS,
  parameter logic [7:0] CMD_ALL     = DEF_CMD_ALL,
  parameter logic [7:0] FRAME_HDR   = DEF_FRAME_HDR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_ready,
  input  logic                           result_valid,
  input  logic [IDX_W-1:0]               result_digit,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores_flat,
  output logic [7:0]                     tx_data,
  output logic                           tx_send,
  input  logic                           tx_busy,
  output logic                           busy,
  output logic                           has_result,
  output logic [7:0]                     result_count
);

  localparam int SB    = SCORE_W / 8;
  localparam int NB    = NUM_CLASSES * SB;
  localparam int CNT_W = $clog2(NB + 3);

  state_e           r_state;
  rsp_e             r_kind;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;
  logic [7:0]       r_csum;

  logic             w_cmd_hit;
  rsp_e             w_cmd_kind;
  logic             w_to_back;
  logic             w_to_front;
  logic             w_swap;
  logic [CNT_W-1:0] w_byte_idx;
  logic [7:0]       w_score_byte;
  logic [IDX_W-1:0] w_front_digit;
  logic             w_pending;
  logic [7:0]       w_digit_byte;
  logic [5:0]       w_cnt_sat;
  logic [7:0]       w_byte;

  // A result landing during a response (except its final DONE cycle, where the
  // swap happens) is parked so the frame in flight stays consistent.
  assign w_to_back  = result_valid & busy & (r_state != ST_DONE);
  assign w_to_front = result_valid & ~w_to_back;
  assign w_swap     = (r_state == ST_DONE);
  assign w_byte_idx = (r_kind == RSP_ALL) ? r_cnt - CNT_W'(2) : r_cnt;

  result_snapshot_buf #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W),
    .IDX_W       (IDX_W),
    .SEL_W       (CNT_W)
  ) u_snap (
    .clk        (clk),
    .rst        (rst),
    .i_wr_front (w_to_front),
    .i_wr_back  (w_to_back),
    .i_swap     (w_swap),
    .i_digit    (result_digit),
    .i_scores   (scores_flat),
    .i_byte_idx (w_byte_idx),
    .o_byte     (w_score_byte),
    .o_digit    (w_front_digit),
    .o_pending  (w_pending)
  );

  assign w_digit_byte = has_result ? 8'(w_front_digit) : 8'hFF;
  assign w_cnt_sat    = (result_count > 8'd63) ? 6'd63 : result_count[5:0];

  // Opcode decode; anything unrecognised is simply not a hit.
  always_comb begin
    w_cmd_hit  = 1'b0;
    w_cmd_kind = RSP_DIGIT;
    if (rx_ready) begin
      if (rx_data == CMD_DIGIT) begin
        w_cmd_hit = 1'b1;  w_cmd_kind = RSP_DIGIT;
      end else if (rx_data == CMD_SCORES) begin
        w_cmd_hit = 1'b1;  w_cmd_kind = RSP_SCORES;
      end else if (rx_data == CMD_STATUS) begin
        w_cmd_hit = 1'b1;  w_cmd_kind = RSP_STATUS;
      end else if (rx_data == CMD_ALL) begin
        w_cmd_hit = 1'b1;  w_cmd_kind = RSP_ALL;
      end
    end
  end

  // Byte to send at position r_cnt of the current response.
  always_comb begin
    w_byte = 8'h00;
    case (r_kind)
      RSP_DIGIT:  w_byte = w_digit_byte;
      RSP_SCORES: w_byte = w_score_byte;
      RSP_STATUS: w_byte = {has_result, w_pending, w_cnt_sat};
      RSP_ALL: begin
        if (r_cnt == '0)                w_byte = FRAME_HDR;
        else if (r_cnt == CNT_W'(1))    w_byte = w_digit_byte;
        else if (r_cnt == r_last)       w_byte = r_csum;
        else                            w_byte = w_score_byte;
      end
    endcase
  end

  // Response FSM plus result counters; all outputs are registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_kind       <= RSP_DIGIT;
      r_cnt        <= '0;
      r_last       <= '0;
      r_csum       <= 8'h00;
      tx_data      <= 8'h00;
      tx_send      <= 1'b0;
      busy         <= 1'b0;
      has_result   <= 1'b0;
      result_count <= 8'h00;
    end else begin
      tx_send <= 1'b0;
      if (result_valid) begin
        has_result <= 1'b1;
        if (result_count != 8'hFF) result_count <= result_count + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hit) begin
            r_kind  <= w_cmd_kind;
            r_cnt   <= '0;
            r_last  <= CNT_W'(resp_len(w_cmd_kind, NB) - 1);
            r_csum  <= 8'h00;
            busy    <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_data <= w_byte;
          r_csum  <= r_csum ^ w_byte;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_send <= 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP:  r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!tx_busy) begin
            if (r_cnt == r_last) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_server.sv
// Scoreboard bench for uart_result_server: stimulus pushes expected bytes, a
// negedge monitor pops and compares on every tx_send and models uart_tx busy.
module tb_uart_result_server;

  localparam int NC = 10;
  localparam int SW = 32;
  localparam int IW = 4;
  localparam int NB = NC * SW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              result_valid;
  logic [IW-1:0]     result_digit;
  logic [NC*SW-1:0]  scores_flat;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_busy;
  logic              busy;
  logic              has_result;
  logic [7:0]        result_count;

  logic [7:0] sb[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int n_sent    = 0;
  int busy_hold = 3;
  int busy_cnt  = 0;

  logic [NC*SW-1:0] scores_a;
  logic [NC*SW-1:0] scores_b;

  uart_result_server dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .scores_flat  (scores_flat),
    .tx_data      (tx_data),
    .tx_send      (tx_send),
    .tx_busy      (tx_busy),
    .busy         (busy),
    .has_result   (has_result),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor + uart_tx model: compare every sent byte, then hold tx_busy.
  always @(negedge clk) begin
    if (tx_send === 1'b1) begin
      logic [7:0] exp_b;
      n_sent++;
      check("tx_send while tx_busy", 32'(tx_busy), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected tx byte: got 0x%0h, expected none", tx_data);
      end else begin
        exp_b = sb.pop_front();
        check($sformatf("tx byte #%0d", n_sent), 32'(tx_data), 32'(exp_b));
      end
      tx_busy  = 1'b1;
      busy_cnt = busy_hold;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_result(input logic [IW-1:0] d, input logic [NC*SW-1:0] s);
    @(negedge clk);
    result_valid = 1'b1;
    result_digit = d;
    scores_flat  = s;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic push_scores(input logic [NC*SW-1:0] s);
    for (int k = 0; k < NB; k++) sb.push_back(s[k*8 +: 8]);
  endtask

  task automatic push_frame(input logic [7:0] dbyte, input logic [NC*SW-1:0] s);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'hA5;
    sb.push_back(8'hA5);
    sb.push_back(dbyte);
    cs = cs ^ dbyte;
    for (int k = 0; k < NB; k++) begin
      b = s[k*8 +: 8];
      sb.push_back(b);
      cs = cs ^ b;
    end
    sb.push_back(cs);
  endtask

  // Wait until the response finishes and every expected byte has appeared.
  task automatic wait_done(input string name, input int budget);
    int cyc;
    cyc = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " bytes outstanding"}, 32'(sb.size()), 32'd0);
    check({name, " completed in budget"}, 32'(cyc < budget), 32'd1);
    sb.delete();
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int cyc;
    rst          = 1'b0;
    rx_data      = 8'h00;
    rx_ready     = 1'b0;
    result_valid = 1'b0;
    result_digit = '0;
    scores_flat  = '0;
    tx_busy      = 1'b0;
    scores_a     = '0;
    scores_a[3*SW +: SW] = 32'h1234_5678;
    scores_b     = '0;
    scores_b[0*SW +: SW] = 32'hAABB_CCDD;
    scores_b[9*SW +: SW] = 32'h0102_0304;

    repeat (3) @(negedge clk);
    check("reset tx_send", 32'(tx_send), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset has_result", 32'(has_result), 32'd0);
    check("reset result_count", 32'(result_count), 32'd0);
    rst = 1'b1;

    // No result yet: digit 0xFF, status 0x00.
    sb.push_back(8'hFF);  send_cmd(8'hCC);  wait_done("digit empty", 200);
    sb.push_back(8'h00);  send_cmd(8'hCE);  wait_done("status empty", 200);

    // First result, raw scores and framed response.
    pulse_result(4'd7, scores_a);
    check("has_result after capture", 32'(has_result), 32'd1);
    check("result_count after capture", 32'(result_count), 32'd1);
    push_scores(scores_a);          send_cmd(8'hCD);  wait_done("scores", 2000);
    push_frame(8'h07, scores_a);    send_cmd(8'hCF);  wait_done("frame", 2000);

    // New result mid-response must not tear the frame; CE mid-response ignored.
    push_scores(scores_a);
    send_cmd(8'hCD);
    repeat (20) @(negedge clk);
    pulse_result(4'd2, scores_b);
    send_cmd(8'hCE);
    wait_done("scores untorn", 2000);
    sb.push_back(8'h02);            send_cmd(8'hCC);  wait_done("digit after swap", 200);
    push_scores(scores_b);          send_cmd(8'hCD);  wait_done("scores after swap", 2000);

    // Command and result in the same cycle: response uses the new sample.
    sb.push_back(8'h05);
    @(negedge clk);
    rx_data = 8'hCC;  rx_ready = 1'b1;
    result_valid = 1'b1;  result_digit = 4'd5;  scores_flat = scores_b;
    @(negedge clk);
    rx_ready = 1'b0;  result_valid = 1'b0;
    wait_done("same-cycle capture", 200);
    check("result_count after 3 results", 32'(result_count), 32'd3);

    // Slow uart_tx; bytes sent while busy are ignored.
    busy_hold = 500;
    base = n_sent;
    sb.push_back(8'h05);
    send_cmd(8'hCC);
    repeat (50) @(negedge clk);
    check("busy during slow send", 32'(busy), 32'd1);
    send_cmd(8'h55);
    send_cmd(8'hCC);
    wait_done("slow tx", 3000);
    repeat (600) @(negedge clk);
    check("single send while busy", 32'(n_sent - base), 32'd1);
    busy_hold = 3;

    // Saturating counter and status byte.
    @(negedge clk);
    result_valid = 1'b1;  result_digit = 4'd9;  scores_flat = scores_a;
    repeat (300) @(negedge clk);
    result_valid = 1'b0;
    check("result_count saturated", 32'(result_count), 32'd255);
    sb.push_back(8'hBF);  send_cmd(8'hCE);  wait_done("status saturated", 200);

    // Reset in the middle of a framed response.
    push_frame(8'h09, scores_a);
    base = n_sent;
    send_cmd(8'hCF);
    cyc = 0;
    while (n_sent < base + 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("bytes before mid reset", 32'(n_sent >= base + 5), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
    base = n_sent;
    check("mid reset tx_send", 32'(tx_send), 32'd0);
    check("mid reset tx_data", 32'(tx_data), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset has_result", 32'(has_result), 32'd0);
    check("mid reset result_count", 32'(result_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("no tx_send after reset", 32'(n_sent - base), 32'd0);
    sb.push_back(8'hFF);  send_cmd(8'hCC);  wait_done("digit after reset", 200);
    sb.push_back(8'h00);  send_cmd(8'hCE);  wait_done("status after reset", 200);
    push_scores('0);      send_cmd(8'hCD);  wait_done("scores after reset", 2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
